// File: rtl/booth_mult_seq_pkg.sv
// rtl/booth_mult_seq_pkg.sv - shared state encoding and Booth select codes
package booth_mult_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Handshake shape shared with the divider: done lasts one cycle in IDLE.
    localparam int unsigned HS_DONE_CYCLES = 1;

    function automatic logic booth_sel_active(input logic [1:0] sel);
        return (sel == BOOTH_ADD) || (sel == BOOTH_SUB);
    endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - start/busy/done multiply handshake bundle
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq_addsub_nbit.sv
// rtl/booth_mult_seq_addsub_nbit.sv - ripple adder/subtractor, sum = a + (b ^ {N{sub}}) + sub
module addsub_nbit #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum
);
    logic [N-1:0] carry;
    logic [N-1:0] b_eff;

    assign carry[0] = sub;
    assign b_eff    = b ^ {N{sub}};

    // Final carry-out is deliberately not produced; the accumulator is wide enough.
    for (genvar i = 0; i < N; i++) begin : g_cell
        assign sum[i] = a[i] ^ b_eff[i] ^ carry[i];
        if (i < N - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    end
endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, one step per clock
module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    booth_mult_seq_if.slave   bus
);
    import booth_mult_seq_pkg::*;

    state_e               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [1:0]           sel;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       t;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;

    assign sel = {q_q[0], qm1_q};

    addsub_nbit #(.N(WIDTH + 1)) u_addsub (
        .a   (a_q),
        .b   (m_q),
        .sub (sel == BOOTH_SUB),
        .sum (sum)
    );

    // Arithmetic shift of {T, Q, q_m1} as one wide register.
    always_comb begin
        t       = booth_sel_active(sel) ? sum : a_q;
        a_shift = {t[WIDTH], t[WIDTH:1]};
        q_shift = {t[0], q_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        count_d   = count_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = '0;
                    q_d     = bus.multiplier;
                    qm1_d   = 1'b0;
                    m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
                    count_d = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_shift;
                q_d     = q_shift;
                qm1_d   = q_q[0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    product_d = {a_shift[WIDTH-1:0], q_shift};
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule
